// File: rtl/rob_pkg.sv
// ============================================================================
// Module      : rob_pkg
// Description : Shared reorder-buffer sizing and entry layout for ROB, RS and rename.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package rob_pkg;

  localparam int ROB_DEPTH = 64;
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH);
  localparam int PREG_W    = 6;
  localparam int AREG_W    = 5;
  localparam int VALUE_W   = 32;
  localparam int NUM_FU    = 3;

  localparam logic [ROB_IDX_W:0] ROB_FULL_COUNT = (ROB_IDX_W+1)'(ROB_DEPTH);

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;

  // Per-entry payload; valid/done live in separate vectors so retire select can scan them.
  typedef struct packed {
    logic              has_rd;
    logic [AREG_W-1:0] arch_rd;
    logic [PREG_W-1:0] phys_rd;
    logic [PREG_W-1:0] old_phys_rd;
    logic [VALUE_W-1:0] value;
  } rob_payload_t;

endpackage

`default_nettype wire

// File: rtl/rob_retire_select.sv
// ============================================================================
// Module      : rob_retire_select
// Description : Picks up to two in-order retiring entries starting at the head.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rob_retire_select
  import rob_pkg::*;
(
  input  logic [ROB_IDX_W-1:0] head_idx,
  input  logic [ROB_DEPTH-1:0] valid_vec,
  input  logic [ROB_DEPTH-1:0] done_vec,
  output logic [1:0]           retire_count,
  output logic [ROB_IDX_W-1:0] retire_idx_0,
  output logic [ROB_IDX_W-1:0] retire_idx_1
);

  logic ready_0;
  logic ready_1;

  always_comb begin
    retire_idx_0 = head_idx;
    retire_idx_1 = head_idx + ROB_IDX_W'(1);
    ready_0      = valid_vec[retire_idx_0] && done_vec[retire_idx_0];
    ready_1      = valid_vec[retire_idx_1] && done_vec[retire_idx_1];
    retire_count = 2'd0;
    // Slot 1 may only fire behind slot 0 to keep program order.
    if (ready_0) begin
      retire_count = ready_1 ? 2'd2 : 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/reorder_buffer.sv
// ============================================================================
// Module      : reorder_buffer
// Description : Circular in-order ROB: 1 alloc/cycle, 3 completion ports, 2 retires/cycle.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module reorder_buffer
  import rob_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_valid,
  input  logic                 alloc_has_rd,
  input  logic [AREG_W-1:0]    alloc_arch_rd,
  input  logic [PREG_W-1:0]    alloc_phys_rd,
  input  logic [PREG_W-1:0]    alloc_old_phys_rd,
  output logic [ROB_IDX_W-1:0] alloc_rob_num,
  output logic                 rob_full,
  output logic [ROB_IDX_W:0]   rob_count,
  input  logic                 complete_fu1_valid,
  input  logic [ROB_IDX_W-1:0] complete_fu1_rob_num,
  input  logic [VALUE_W-1:0]   complete_fu1_value,
  input  logic                 complete_fu2_valid,
  input  logic [ROB_IDX_W-1:0] complete_fu2_rob_num,
  input  logic [VALUE_W-1:0]   complete_fu2_value,
  input  logic                 complete_fu3_valid,
  input  logic [ROB_IDX_W-1:0] complete_fu3_rob_num,
  input  logic [VALUE_W-1:0]   complete_fu3_value,
  output logic                 retire_0_valid,
  output logic                 retire_0_has_rd,
  output logic [AREG_W-1:0]    retire_0_arch_rd,
  output logic [PREG_W-1:0]    retire_0_phys_rd,
  output logic [PREG_W-1:0]    retire_0_old_phys_rd,
  output logic [VALUE_W-1:0]   retire_0_value,
  output logic [ROB_IDX_W-1:0] retire_0_rob_num,
  output logic                 retire_1_valid,
  output logic                 retire_1_has_rd,
  output logic [AREG_W-1:0]    retire_1_arch_rd,
  output logic [PREG_W-1:0]    retire_1_phys_rd,
  output logic [PREG_W-1:0]    retire_1_old_phys_rd,
  output logic [VALUE_W-1:0]   retire_1_value,
  output logic [ROB_IDX_W-1:0] retire_1_rob_num
);

  logic [ROB_DEPTH-1:0] valid_q, valid_d;
  logic [ROB_DEPTH-1:0] done_q, done_d;
  rob_payload_t         payload_q [ROB_DEPTH];
  rob_payload_t         payload_d [ROB_DEPTH];

  rob_idx_t             head_q, head_d;
  rob_idx_t             tail_q, tail_d;
  logic [ROB_IDX_W:0]   count_q, count_d;

  logic [1:0]           ret_valid_q, ret_valid_d;
  rob_payload_t         ret_pl_q [2];
  rob_payload_t         ret_pl_d [2];
  rob_idx_t             ret_rob_q [2];
  rob_idx_t             ret_rob_d [2];

  logic [NUM_FU-1:0]    fu_valid;
  rob_idx_t             fu_rob [NUM_FU];
  logic [VALUE_W-1:0]   fu_value [NUM_FU];

  logic [1:0]           retire_count;
  rob_idx_t             retire_idx_0;
  rob_idx_t             retire_idx_1;
  logic                 alloc_accept;

  rob_retire_select u_retire_select (
    .head_idx     (head_q),
    .valid_vec    (valid_q),
    .done_vec     (done_q),
    .retire_count (retire_count),
    .retire_idx_0 (retire_idx_0),
    .retire_idx_1 (retire_idx_1)
  );

  assign rob_full      = (count_q == ROB_FULL_COUNT);
  assign rob_count     = count_q;
  assign alloc_rob_num = tail_q;
  assign alloc_accept  = alloc_valid && !rob_full;

  always_comb begin
    fu_valid    = {complete_fu3_valid, complete_fu2_valid, complete_fu1_valid};
    fu_rob[0]   = complete_fu1_rob_num;
    fu_rob[1]   = complete_fu2_rob_num;
    fu_rob[2]   = complete_fu3_rob_num;
    fu_value[0] = complete_fu1_value;
    fu_value[1] = complete_fu2_value;
    fu_value[2] = complete_fu3_value;
  end

  always_comb begin
    valid_d   = valid_q;
    done_d    = done_q;
    payload_d = payload_q;

    // Walk from the highest port down so FU1 lands last when ports collide.
    for (int f = NUM_FU - 1; f >= 0; f--) begin
      if (fu_valid[f] && valid_q[fu_rob[f]]) begin
        done_d[fu_rob[f]]          = 1'b1;
        payload_d[fu_rob[f]].value = fu_value[f];
      end
    end

    if (retire_count != 2'd0) begin
      valid_d[retire_idx_0] = 1'b0;
      done_d[retire_idx_0]  = 1'b0;
    end
    if (retire_count == 2'd2) begin
      valid_d[retire_idx_1] = 1'b0;
      done_d[retire_idx_1]  = 1'b0;
    end

    // Allocation is last so it overrides any stray completion on the tail slot.
    if (alloc_accept) begin
      valid_d[tail_q]               = 1'b1;
      done_d[tail_q]                = 1'b0;
      payload_d[tail_q].has_rd      = alloc_has_rd;
      payload_d[tail_q].arch_rd     = alloc_arch_rd;
      payload_d[tail_q].phys_rd     = alloc_phys_rd;
      payload_d[tail_q].old_phys_rd = alloc_old_phys_rd;
      payload_d[tail_q].value       = '0;
    end
  end

  always_comb begin
    head_d  = head_q + rob_idx_t'(retire_count);
    tail_d  = tail_q + rob_idx_t'(alloc_accept);
    count_d = count_q + (ROB_IDX_W+1)'(alloc_accept) - (ROB_IDX_W+1)'(retire_count);
  end

  always_comb begin
    ret_valid_d[0] = (retire_count != 2'd0);
    ret_valid_d[1] = (retire_count == 2'd2);
    ret_pl_d       = ret_pl_q;
    ret_rob_d      = ret_rob_q;
    if (ret_valid_d[0]) begin
      ret_pl_d[0]  = payload_q[retire_idx_0];
      ret_rob_d[0] = retire_idx_0;
    end
    if (ret_valid_d[1]) begin
      ret_pl_d[1]  = payload_q[retire_idx_1];
      ret_rob_d[1] = retire_idx_1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= '0;
      done_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ret_valid_q <= '0;
      for (int s = 0; s < 2; s++) begin
        ret_pl_q[s]  <= '0;
        ret_rob_q[s] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      done_q      <= done_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      ret_valid_q <= ret_valid_d;
      ret_pl_q    <= ret_pl_d;
      ret_rob_q   <= ret_rob_d;
    end
  end

  // Payload storage is qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    payload_q <= payload_d;
  end

  assign retire_0_valid       = ret_valid_q[0];
  assign retire_0_has_rd      = ret_pl_q[0].has_rd;
  assign retire_0_arch_rd     = ret_pl_q[0].arch_rd;
  assign retire_0_phys_rd     = ret_pl_q[0].phys_rd;
  assign retire_0_old_phys_rd = ret_pl_q[0].old_phys_rd;
  assign retire_0_value       = ret_pl_q[0].value;
  assign retire_0_rob_num     = ret_rob_q[0];
  assign retire_1_valid       = ret_valid_q[1];
  assign retire_1_has_rd      = ret_pl_q[1].has_rd;
  assign retire_1_arch_rd     = ret_pl_q[1].arch_rd;
  assign retire_1_phys_rd     = ret_pl_q[1].phys_rd;
  assign retire_1_old_phys_rd = ret_pl_q[1].old_phys_rd;
  assign retire_1_value       = ret_pl_q[1].value;
  assign retire_1_rob_num     = ret_rob_q[1];

endmodule

`default_nettype wire
